// File: rtl/ram_port_initiator.sv
// ram_port_initiator: drives one port of the latency dual-port RAM from a
// valid/ready request stream. It tracks in-flight reads and returns their data
// with the request address attached.
// Optional feature macro: RAM_INIT_RAW_STALL_EN. When defined, a read that
// would hit a not-yet-committed write is held off. When undefined, the write
// tracker is removed and such a read returns stale array data.
module ram_port_initiator #(
  parameter int DATA_WIDTH = 8,
  parameter int MEM_DEPTH  = 16,
  parameter int ADDR_WIDTH = $clog2(MEM_DEPTH),
  parameter int WR_LATENCY = 1,
  parameter int RD_LATENCY = 1
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              i_req_valid,
  output logic                              o_req_ready,
  input  logic                              i_req_we,
  input  logic [ADDR_WIDTH-1:0]             i_req_addr,
  input  logic [DATA_WIDTH-1:0]             i_req_wdata,
  output logic                              o_rsp_valid,
  output logic [DATA_WIDTH-1:0]             o_rsp_rdata,
  output logic [ADDR_WIDTH-1:0]             o_rsp_addr,
  output logic [$clog2(RD_LATENCY+2)-1:0]   o_outstanding,
  output logic                              o_en,
  output logic                              o_we,
  output logic [ADDR_WIDTH-1:0]             o_addr,
  output logic [DATA_WIDTH-1:0]             o_din,
  input  logic [DATA_WIDTH-1:0]             i_dout
);

  localparam int OUT_W = $clog2(RD_LATENCY+2);

  logic accept;
  logic rd_acc;
  logic rd_ret;

  // Read tracker: one {valid, addr} entry per cycle of RAM read latency.
  logic [RD_LATENCY-1:0]                 rd_vld_pipe;
  logic [RD_LATENCY-1:0][ADDR_WIDTH-1:0] rd_addr_pipe;

  assign accept = i_req_valid & o_req_ready;
  assign rd_acc = accept & ~i_req_we;
  // The last tracker stage is the cycle whose end carries valid i_dout.
  assign rd_ret = rd_vld_pipe[RD_LATENCY-1];

`ifdef RAM_INIT_RAW_STALL_EN
  // Write tracker is loaded at accept, so entry 0 shadows the issue stage and
  // the last entry leaves exactly when the array commit becomes visible.
  logic [WR_LATENCY-1:0]                 wr_vld_pipe;
  logic [WR_LATENCY-1:0][ADDR_WIDTH-1:0] wr_addr_pipe;
  logic                                  raw_hit;

  // Shift the write tracker; an accepted write enters at the head.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_vld_pipe  <= '0;
      wr_addr_pipe <= '0;
    end else begin
      wr_vld_pipe[0]  <= accept & i_req_we;
      wr_addr_pipe[0] <= i_req_addr;
      for (int i = 1; i < WR_LATENCY; i++) begin
        wr_vld_pipe[i]  <= wr_vld_pipe[i-1];
        wr_addr_pipe[i] <= wr_addr_pipe[i-1];
      end
    end
  end

  // Compare the request address against the issue stage and every pending write.
  always_comb begin
    raw_hit = o_en & o_we & (o_addr == i_req_addr);
    for (int i = 0; i < WR_LATENCY; i++) begin
      if (wr_vld_pipe[i] && (wr_addr_pipe[i] == i_req_addr)) raw_hit = 1'b1;
    end
  end

  // Only reads stall; writes to a pending address simply overwrite later.
  assign o_req_ready = rst_n & (i_req_we | ~raw_hit);
`else
  assign o_req_ready = rst_n;
`endif

  // Issue stage: one-cycle enable pulse; address and data hold when idle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      o_en   <= 1'b0;
      o_we   <= 1'b0;
      o_addr <= '0;
      o_din  <= '0;
    end else begin
      o_en <= accept;
      o_we <= accept & i_req_we;
      if (accept) begin
        o_addr <= i_req_addr;
        o_din  <= i_req_wdata;
      end
    end
  end

  // Read tracker: a read on the pins enters at the head and walks the latency.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_vld_pipe  <= '0;
      rd_addr_pipe <= '0;
    end else begin
      rd_vld_pipe[0]  <= o_en & ~o_we;
      rd_addr_pipe[0] <= o_addr;
      for (int i = 1; i < RD_LATENCY; i++) begin
        rd_vld_pipe[i]  <= rd_vld_pipe[i-1];
        rd_addr_pipe[i] <= rd_addr_pipe[i-1];
      end
    end
  end

  // Response register: capture i_dout at the end of the read's last latency cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      o_rsp_valid <= 1'b0;
      o_rsp_rdata <= '0;
      o_rsp_addr  <= '0;
    end else begin
      o_rsp_valid <= rd_ret;
      if (rd_ret) begin
        o_rsp_rdata <= i_dout;
        o_rsp_addr  <= rd_addr_pipe[RD_LATENCY-1];
      end
    end
  end

  // Outstanding reads: a read leaves the count on the edge its response is raised.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      o_outstanding <= '0;
    end else begin
      case ({rd_acc, rd_ret})
        2'b10:   o_outstanding <= o_outstanding + OUT_W'(1);
        2'b01:   o_outstanding <= o_outstanding - OUT_W'(1);
        default: o_outstanding <= o_outstanding;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_port_initiator.sv
// tb_ram_port_initiator: directed bench for ram_port_initiator with
// WR_LATENCY=2 and RD_LATENCY=3, against a small behavioural RAM port.
module tb_ram_port_initiator;

  logic       clk;
  logic       rst_n;
  logic       i_req_valid;
  logic       o_req_ready;
  logic       i_req_we;
  logic [3:0] i_req_addr;
  logic [7:0] i_req_wdata;
  logic       o_rsp_valid;
  logic [7:0] o_rsp_rdata;
  logic [3:0] o_rsp_addr;
  logic [2:0] o_outstanding;
  logic       o_en;
  logic       o_we;
  logic [3:0] o_addr;
  logic [7:0] o_din;
  logic [7:0] i_dout;

  ram_port_initiator #(
    .DATA_WIDTH(8), .MEM_DEPTH(16), .ADDR_WIDTH(4), .WR_LATENCY(2), .RD_LATENCY(3)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .i_req_valid(i_req_valid), .o_req_ready(o_req_ready),
    .i_req_we(i_req_we), .i_req_addr(i_req_addr), .i_req_wdata(i_req_wdata),
    .o_rsp_valid(o_rsp_valid), .o_rsp_rdata(o_rsp_rdata), .o_rsp_addr(o_rsp_addr),
    .o_outstanding(o_outstanding),
    .o_en(o_en), .o_we(o_we), .o_addr(o_addr), .o_din(o_din), .i_dout(i_dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // RAM port model: write commits WR_LATENCY=2 edges after its pin cycle,
  // read data is valid RD_LATENCY=3 cycles after its pin cycle.
  logic [7:0] mem [16];
  bit         preloaded = 1'b0;
  logic       wv;
  logic [3:0] wa;
  logic [7:0] wd;
  logic [7:0] rd0, rd1;
  always @(posedge clk) begin
    if (!preloaded) begin
      for (int i = 0; i < 16; i++) mem[i] <= 8'h10 + 8'(i);
      preloaded <= 1'b1;
    end
    wv <= o_en & o_we;
    wa <= o_addr;
    wd <= o_din;
    if (wv) mem[wa] <= wd;
    if (o_en & ~o_we) rd0 <= mem[o_addr];
    rd1    <= rd0;
    i_dout <= rd1;
  end

  // Response collector and outstanding high-water mark.
  int         rsp_cyc[$];
  logic [7:0] rsp_data[$];
  logic [3:0] rsp_addr[$];
  int         max_out;
  always @(negedge clk) begin
    if (o_rsp_valid === 1'b1) begin
      rsp_cyc.push_back(cyc);
      rsp_data.push_back(o_rsp_rdata);
      rsp_addr.push_back(o_rsp_addr);
    end
    if (int'(o_outstanding) > max_out) max_out = int'(o_outstanding);
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic clear_rsp();
    rsp_cyc.delete();
    rsp_data.delete();
    rsp_addr.delete();
  endtask

  // Called at a negedge; presents a request until accepted, returns at the
  // negedge after the accepting edge with valid still asserted.
  task automatic req(input bit we, input logic [3:0] a, input logic [7:0] d,
                     output int acc, output int stalls);
    bit r;
    acc    = -1;
    stalls = 0;
    i_req_valid = 1'b1;
    i_req_we    = we;
    i_req_addr  = a;
    i_req_wdata = d;
    for (int k = 0; k < 20; k++) begin
      #1 r = o_req_ready;
      @(posedge clk);
      #1;
      if (r) begin
        acc = cyc;
        break;
      end
      stalls++;
      @(negedge clk);
    end
    if (acc < 0) check("req_timeout", stalls, 0);
    @(negedge clk);
  endtask

  task automatic idle();
    i_req_valid = 1'b0;
    i_req_we    = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  int acc_s[8];
  int aw, ar, st;

  initial begin
    rst_n       = 1'b0;
    i_req_valid = 1'b1;
    i_req_we    = 1'b0;
    i_req_addr  = 4'd0;
    i_req_wdata = 8'd0;
    max_out     = 0;

    // Reset held for three edges with a request pending.
    repeat (3) begin
      @(posedge clk);
      @(negedge clk);
      check("rst_ready", o_req_ready, 0);
      check("rst_en", o_en, 0);
      check("rst_rsp_valid", o_rsp_valid, 0);
      check("rst_outstanding", o_outstanding, 0);
    end
    check("rst_we", o_we, 0);
    check("rst_addr", o_addr, 0);
    check("rst_din", o_din, 0);
    check("rst_rsp_rdata", o_rsp_rdata, 0);
    check("rst_rsp_addr", o_rsp_addr, 0);
    rst_n = 1'b1;
    idle();
    #1 check("release_ready", o_req_ready, 1);

    // Streaming reads of addresses 0..7.
    @(negedge clk);
    clear_rsp();
    max_out = 0;
    for (int i = 0; i < 8; i++) req(1'b0, 4'(i), 8'h00, acc_s[i], st);
    idle();
    repeat (8) @(negedge clk);
    check("stream_count", rsp_cyc.size(), 8);
    check("stream_accept_b2b", acc_s[7] - acc_s[0], 7);
    check("stream_first_lat", rsp_cyc[0] - acc_s[0], 4);
    for (int i = 0; i < 8; i++) begin
      check("stream_data", rsp_data[i], 8'h10 + 8'(i));
      check("stream_addr", rsp_addr[i], 4'(i));
      check("stream_cyc", rsp_cyc[i] - rsp_cyc[0], i);
    end
    check("stream_peak_out", max_out, 4);
    check("stream_out_drained", o_outstanding, 0);

    // Write addr 5 then read addr 5 on the next edge.
    clear_rsp();
    req(1'b1, 4'd5, 8'hA5, aw, st);
    check("wr_pin_en", o_en, 1);
    check("wr_pin_we", o_we, 1);
    check("wr_pin_addr", o_addr, 5);
    check("wr_pin_din", o_din, 8'hA5);
    req(1'b0, 4'd5, 8'h00, ar, st);
    idle();
    check("rd_pin_en", o_en, 1);
    check("rd_pin_we", o_we, 0);
    check("rd_pin_addr", o_addr, 5);
    repeat (8) @(negedge clk);
    check("raw_rsp_count", rsp_cyc.size(), 1);
    check("raw_rsp_addr", rsp_addr[0], 5);
    check("raw_rsp_cyc", rsp_cyc[0] - aw, ar - aw + 4);
`ifdef RAM_INIT_RAW_STALL_EN
    check("raw_stalls", st, 2);
    check("raw_accept_gap", ar - aw, 3);
    check("raw_rsp_data", rsp_data[0], 8'hA5);
    check("raw_rsp_cycle_n8", rsp_cyc[0] - aw, 7);
`else
    check("raw_stalls", st, 0);
    check("raw_accept_gap", ar - aw, 1);
    check("raw_rsp_data", rsp_data[0], 8'h15);
`endif

    // Write addr 3 then read addr 4: no hazard.
    clear_rsp();
    req(1'b1, 4'd3, 8'h33, aw, st);
    req(1'b0, 4'd4, 8'h00, ar, st);
    idle();
    repeat (8) @(negedge clk);
    check("nohaz_stalls", st, 0);
    check("nohaz_gap", ar - aw, 1);
    check("nohaz_rsp_count", rsp_cyc.size(), 1);
    check("nohaz_rsp_data", rsp_data[0], 8'h14);
    check("nohaz_rsp_addr", rsp_addr[0], 4);
    check("nohaz_rsp_lat", rsp_cyc[0] - ar, 4);

    // Mid-flight reset with three reads outstanding.
    clear_rsp();
    req(1'b0, 4'd0, 8'h00, aw, st);
    req(1'b0, 4'd1, 8'h00, aw, st);
    req(1'b0, 4'd2, 8'h00, aw, st);
    idle();
    check("mid_out_before", o_outstanding, 3);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("mid_out_after", o_outstanding, 0);
    check("mid_rsp_valid", o_rsp_valid, 0);
    repeat (8) @(negedge clk);
    check("mid_no_rsp", rsp_cyc.size(), 0);
    check("mid_out_final", o_outstanding, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
